// File: rtl/price_table_writer.sv
// Write side of the fare table BRAM: generates the 100x100 fare table at
// addresses 0..9999 and applies single-entry fare overrides on port A.
module price_table_writer #(
  parameter int unsigned N_STATIONS = 100,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_start,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [6:0]        upd_start,
  input  logic [6:0]        upd_end,
  input  logic [3:0]        upd_price,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              fill_done,
  output logic              upd_err
);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, UPD} state_t;

  localparam logic [6:0] LAST_IDX = 7'(N_STATIONS - 1);

  state_t      state_q, state_d;
  logic [6:0]  s_q, e_q;
  logic [13:0] addr_cnt_q;
  logic        v1_q;
  logic [3:0]  fare1_q;
  logic [13:0] addr1_q;

  logic        upd_idx_ok;
  logic        upd_accept;
  logic        upd_reject;
  logic        fill_last;
  logic [6:0]  hops;
  logic [13:0] upd_addr;

  function automatic logic [3:0] fare_of(input logic [6:0] h);
    if (h == 7'd0)       fare_of = 4'd0;
    else if (h <= 7'd4)  fare_of = 4'd2;
    else if (h <= 7'd8)  fare_of = 4'd3;
    else if (h <= 7'd16) fare_of = 4'd4;
    else if (h <= 7'd32) fare_of = 4'd5;
    else                 fare_of = 4'd6;
  endfunction

  always_comb begin
    upd_idx_ok = (upd_start <= LAST_IDX) && (upd_end <= LAST_IDX);
    upd_accept = (state_q == IDLE) && !fill_start && upd_valid && upd_idx_ok;
    upd_reject = (state_q == IDLE) && !fill_start && upd_valid && !upd_idx_ok;
    fill_last  = (s_q == LAST_IDX) && (e_q == LAST_IDX);
    hops       = (s_q > e_q) ? (s_q - e_q) : (e_q - s_q);
    // start*100 as start*64 + start*32 + start*4
    upd_addr   = 14'({upd_start, 6'b0}) + 14'({upd_start, 5'b0})
               + 14'({upd_start, 2'b0}) + 14'(upd_end);
    upd_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fill_start)      state_d = FILL;
        else if (upd_accept) state_d = UPD;
      end
      FILL:    if (fill_last) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      UPD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Row/column counters plus a running address, so no multiplier on the fill path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= '0;
      e_q        <= '0;
      addr_cnt_q <= '0;
    end else if (state_q == FILL && !fill_last) begin
      addr_cnt_q <= addr_cnt_q + 14'd1;
      if (e_q == LAST_IDX) begin
        e_q <= '0;
        s_q <= s_q + 7'd1;
      end else begin
        e_q <= e_q + 7'd1;
      end
    end else begin
      s_q        <= '0;
      e_q        <= '0;
      addr_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      fare1_q <= '0;
      addr1_q <= '0;
    end else begin
      v1_q    <= (state_q == FILL);
      fare1_q <= fare_of(hops);
      addr1_q <= addr_cnt_q;
    end
  end

  // Fill and override writes never coincide: stage 1 is empty by the time IDLE is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      fill_done <= 1'b0;
      upd_err   <= 1'b0;
    end else begin
      fill_done <= (state_q == FLUSH);
      upd_err   <= upd_reject;
      if (v1_q) begin
        ram_we   <= 1'b1;
        ram_addr <= ADDR_W'(addr1_q);
        ram_din  <= {{(DATA_W-4){1'b0}}, fare1_q};
      end else if (upd_accept) begin
        ram_we   <= 1'b1;
        ram_addr <= ADDR_W'(upd_addr);
        ram_din  <= {{(DATA_W-4){1'b0}}, upd_price};
      end else begin
        ram_we   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_price_table_writer.sv
// Bench for price_table_writer: directed fill/override sequences with a
// table of hand-computed fare spot checks.
module tb_price_table_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fill_start;
  logic        upd_valid;
  logic        upd_ready;
  logic [6:0]  upd_start;
  logic [6:0]  upd_end;
  logic [3:0]  upd_price;
  logic        ram_we;
  logic [18:0] ram_addr;
  logic [11:0] ram_din;
  logic        busy;
  logic        fill_done;
  logic        upd_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int oob    = 0;
  logic [11:0] mem [0:9999];

  typedef struct {
    string name;
    int    addr;
    int    din;
  } vec_t;
  vec_t vec [14];

  price_table_writer #(.N_STATIONS(100), .ADDR_W(19), .DATA_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .fill_start(fill_start),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_start(upd_start), .upd_end(upd_end), .upd_price(upd_price),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .busy(busy), .fill_done(fill_done), .upd_err(upd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && ram_we) begin
      if (ram_addr < 19'd10000) mem[ram_addr] = ram_din;
      else oob++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  function automatic logic [11:0] model_fare(input int k);
    int s, e, h;
    s = k / 100;
    e = k % 100;
    h = (s > e) ? s - e : e - s;
    if (h == 0)       return 12'd0;
    else if (h <= 4)  return 12'd2;
    else if (h <= 8)  return 12'd3;
    else if (h <= 16) return 12'd4;
    else if (h <= 32) return 12'd5;
    else              return 12'd6;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"},        32'(ram_we),    0);
    chk({tag, "_addr"},      32'(ram_addr),  0);
    chk({tag, "_din"},       32'(ram_din),   0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_fill_done"}, 32'(fill_done), 0);
    chk({tag, "_upd_err"},   32'(upd_err),   0);
  endtask

  // Pulses fill_start for one cycle and follows the whole write stream.
  // Returns in the cycle carrying the last write (fill_done), or after a reset at abort_at.
  task automatic run_fill(input bit upd_mid, input int abort_at, input string tag);
    int seq_err;
    int first_bad;
    seq_err   = 0;
    first_bad = -1;
    fill_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fill_start = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 1);
    chk({tag, "_we_lat1"},    32'(ram_we), 0);
    chk({tag, "_ready_lat1"}, 32'(upd_ready), 0);
    if (upd_mid) begin
      upd_valid = 1'b1; upd_start = 7'd1; upd_end = 7'd2; upd_price = 4'd5;
    end
    @(negedge clk);
    chk({tag, "_we_lat2"},    32'(ram_we), 0);
    chk({tag, "_ready_lat2"}, 32'(upd_ready), 0);
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        chk({tag, "_we_pre_abort"}, 32'(ram_we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset({tag, "_abort"});
        chk({tag, "_abort_ready"}, 32'(upd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (ram_we !== 1'b1 || ram_addr !== 19'(k) || ram_din !== model_fare(k) ||
          fill_done !== (k == 9999) || busy !== (k != 9999) ||
          (k < 9999 && upd_ready !== 1'b0)) begin
        seq_err++;
        if (first_bad < 0) first_bad = k;
      end
    end
    chk({tag, "_seq_errs"},  32'(seq_err), 0);
    chk({tag, "_first_bad"}, 32'(first_bad), 32'hFFFF_FFFF);
  endtask

  task automatic do_upd(input int s, input int e, input int p, input int exp_addr, input string tag);
    upd_valid = 1'b1; upd_start = 7'(s); upd_end = 7'(e); upd_price = 4'(p);
    chk({tag, "_ready"}, 32'(upd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    chk({tag, "_we"},   32'(ram_we),   1);
    chk({tag, "_addr"}, 32'(ram_addr), 32'(exp_addr));
    chk({tag, "_din"},  32'(ram_din),  32'(p));
    chk({tag, "_busy"}, 32'(busy),     1);
    @(negedge clk);
    chk({tag, "_we_after"},   32'(ram_we), 0);
    chk({tag, "_busy_after"}, 32'(busy),   0);
  endtask

  initial begin
    vec[0]  = '{"a0_s0e0",    0,    0};
    vec[1]  = '{"a1_s0e1",    1,    2};
    vec[2]  = '{"a4_h4",      4,    2};
    vec[3]  = '{"a5_h5",      5,    3};
    vec[4]  = '{"a8_h8",      8,    3};
    vec[5]  = '{"a9_h9",      9,    4};
    vec[6]  = '{"a16_h16",    16,   4};
    vec[7]  = '{"a17_h17",    17,   5};
    vec[8]  = '{"a32_h32",    32,   5};
    vec[9]  = '{"a33_h33",    33,   6};
    vec[10] = '{"a105_s1e5",  105,  2};
    vec[11] = '{"a109_s1e9",  109,  3};
    vec[12] = '{"a9900_s99e0", 9900, 6};
    vec[13] = '{"a9999_s99e99", 9999, 0};

    rst_n = 1'b0; fill_start = 1'b0; upd_valid = 1'b0;
    upd_start = '0; upd_end = '0; upd_price = '0;
    #3;
    chk_reset("reset");
    chk("reset_ready", 32'(upd_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full fill, then spot checks against the captured table
    run_fill(1'b0, -1, "fill1");
    @(negedge clk);
    chk("fill1_we_end",   32'(ram_we),    0);
    chk("fill1_done_end", 32'(fill_done), 0);
    chk("fill1_busy_end", 32'(busy),      0);
    for (int i = 0; i < 14; i++)
      chk(vec[i].name, 32'(mem[vec[i].addr]), 32'(vec[i].din));

    // Override in IDLE
    do_upd(3, 7, 9, 307, "upd37");

    // Out-of-range overrides dropped with an error pulse
    for (int i = 0; i < 2; i++) begin
      upd_valid = 1'b1;
      upd_start = (i == 0) ? 7'd100 : 7'd0;
      upd_end   = (i == 0) ? 7'd0   : 7'd127;
      upd_price = 4'd3;
      @(posedge clk);
      @(negedge clk);
      upd_valid = 1'b0;
      chk($sformatf("err%0d_pulse", i), 32'(upd_err), 1);
      chk($sformatf("err%0d_we", i),    32'(ram_we),  0);
      chk($sformatf("err%0d_busy", i),  32'(busy),    0);
      @(negedge clk);
      chk($sformatf("err%0d_clear", i), 32'(upd_err), 0);
      chk($sformatf("err%0d_we2", i),   32'(ram_we),  0);
    end
    do_upd(99, 99, 15, 9999, "upd9999");

    // Override requested mid-fill waits for the fill to complete
    run_fill(1'b1, -1, "fill2");
    chk("fill2_ready_done", 32'(upd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    chk("fill2_upd_we",   32'(ram_we),   1);
    chk("fill2_upd_addr", 32'(ram_addr), 102);
    chk("fill2_upd_din",  32'(ram_din),  5);
    @(negedge clk);
    chk("fill2_upd_we_after", 32'(ram_we), 0);

    // fill_start and upd_valid on the same edge: fill wins
    upd_valid = 1'b1; upd_start = 7'd50; upd_end = 7'd20; upd_price = 4'd7;
    run_fill(1'b0, -1, "fill3");
    chk("fill3_ready_done", 32'(upd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    chk("fill3_upd_we",   32'(ram_we),   1);
    chk("fill3_upd_addr", 32'(ram_addr), 5020);
    chk("fill3_upd_din",  32'(ram_din),  7);
    @(negedge clk);
    chk("fill3_upd_we_after", 32'(ram_we), 0);

    // Reset mid-fill, then a complete refill from address 0
    run_fill(1'b0, 5000, "fill4");
    @(negedge clk);
    chk("fill4_post_reset_we", 32'(ram_we), 0);
    run_fill(1'b0, -1, "fill5");
    @(negedge clk);
    chk("fill5_we_end", 32'(ram_we), 0);

    chk("no_oob_writes", 32'(oob), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
